// File: rtl/s298_resp_misr.sv
// s298_resp_misr: after a programmable warm-up, folds a LEN-cycle window of the s298
// response into a 16-bit MISR. Define S298_MISR_COMPARE_EN to build the GOLDEN compare.
module s298_resp_misr #(
  parameter int unsigned       SIG_W      = 16,
  parameter logic [SIG_W-1:0]  POLY       = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED       = 16'hFFFF,
  parameter int unsigned       WIN_W      = 8,
  parameter int unsigned       WARMUP_CYC = 4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] LEN,
  input  logic [5:0]       RESP,
  input  logic [SIG_W-1:0] GOLDEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic             PASS
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DONE} state_t;

  localparam logic [7:0] WARM_LOAD = 8'((WARMUP_CYC == 0) ? 0 : WARMUP_CYC - 1);
  localparam state_t     RUN_ENTRY = (WARMUP_CYC == 0) ? S_CAPTURE : S_WARMUP;

  state_t           state_q, state_d;
  logic [7:0]       warm_cnt;
  logic [WIN_W-1:0] cap_cnt;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_next;
  logic             accept;
  logic             last_fold;

  // Shift-with-feedback, then the six response bits enter at the LSB end.
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-6){1'b0}}, RESP};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = RUN_ENTRY;
      S_WARMUP:  if (warm_cnt == '0) state_d = S_CAPTURE;
      S_CAPTURE: if (last_fold) state_d = S_DONE;
      S_DONE: begin
        if (accept)     state_d = RUN_ENTRY;
        else if (START) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_q)
      S_WARMUP, S_CAPTURE: BUSY = 1'b1;
      S_DONE:              DONE = 1'b1;
      default: ;
    endcase
    // A run is only accepted from IDLE or DONE, and a zero-length window is not a run.
    accept    = START && (LEN != '0) && !BUSY;
    last_fold = (state_q == S_CAPTURE) && (cap_cnt == WIN_W'(1));
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      sig_q    <= SEED;
      warm_cnt <= '0;
      cap_cnt  <= '0;
    end else if (accept) begin
      sig_q    <= SEED;
      warm_cnt <= WARM_LOAD;
      cap_cnt  <= LEN;
    end else begin
      case (state_q)
        S_WARMUP: if (warm_cnt != '0) warm_cnt <= warm_cnt - 8'd1;
        S_CAPTURE: begin
          sig_q   <= sig_next;
          cap_cnt <= cap_cnt - WIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign SIG = sig_q;

`ifdef S298_MISR_COMPARE_EN
  logic [SIG_W-1:0] golden_q;
  logic             pass_q;

  // GOLDEN is captured with the run so mid-run changes cannot affect its verdict.
  always_ff @(posedge CK) begin
    if (RST) begin
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else if (accept) begin
      golden_q <= GOLDEN;
      pass_q   <= 1'b0;
    end else if (last_fold) begin
      pass_q   <= (sig_next == golden_q);
    end else if (state_q == S_DONE && START) begin
      pass_q   <= 1'b0;
    end
  end

  assign PASS = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign PASS          = 1'b0;
`endif

endmodule

// File: tb/tb_s298_resp_misr.sv
// Bench for s298_resp_misr: three instances (different SEED / warm-up) driven by directed
// and random runs, checked against a transaction-level signature and timing model.
module tb_s298_resp_misr;

  localparam int N = 3;

  logic        ck = 1'b0;
  logic        rst;
  logic        start  [N];
  logic [7:0]  len    [N];
  logic [5:0]  resp   [N];
  logic [15:0] golden [N];
  logic        busy   [N];
  logic        done   [N];
  logic        pass   [N];
  logic [15:0] sig    [N];

  int total = 0;
  int bad   = 0;

  logic [5:0] dir_q[$];
  int         warm_fix = -1;

  always #5 ck = ~ck;

  s298_resp_misr #(.SEED(16'hFFFF), .WARMUP_CYC(0)) u_d0 (
    .CK(ck), .RST(rst), .START(start[0]), .LEN(len[0]), .RESP(resp[0]), .GOLDEN(golden[0]),
    .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]), .PASS(pass[0]));

  s298_resp_misr #(.SEED(16'h0000), .WARMUP_CYC(0)) u_d1 (
    .CK(ck), .RST(rst), .START(start[1]), .LEN(len[1]), .RESP(resp[1]), .GOLDEN(golden[1]),
    .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]), .PASS(pass[1]));

  s298_resp_misr #(.SEED(16'hFFFF), .WARMUP_CYC(4)) u_d2 (
    .CK(ck), .RST(rst), .START(start[2]), .LEN(len[2]), .RESP(resp[2]), .GOLDEN(golden[2]),
    .BUSY(busy[2]), .DONE(done[2]), .SIG(sig[2]), .PASS(pass[2]));

  function automatic logic [15:0] seed_of(int i);
    return (i == 1) ? 16'h0000 : 16'hFFFF;
  endfunction

  function automatic int warm_of(int i);
    return (i == 2) ? 4 : 0;
  endfunction

  // Polynomial view: multiply by x, reduce mod x^16+x^12+x^5+1, add the response word.
  function automatic logic [15:0] fold(logic [15:0] s, logic [5:0] r);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {10'd0, r};
  endfunction

  function automatic logic want_pass(logic [15:0] s, logic [15:0] g);
`ifdef S298_MISR_COMPARE_EN
    return s == g;
`else
    return (s != s) && (g != g);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete run on instance i; per-cycle BUSY/DONE/SIG/PASS follow from e0 arithmetic.
  task automatic run(input int i, input int l, input bit noisy, output logic [15:0] fin);
    logic [15:0] exp;
    logic [5:0]  r;
    int          w;
    w = warm_of(i);
    @(negedge ck);
    start[i] = 1'b1;
    len[i]   = 8'(l);
    @(posedge ck);
    exp = seed_of(i);
    for (int k = 1; k <= w + l; k++) begin
      @(negedge ck);
      start[i] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      len[i]   = noisy ? 8'($urandom) : len[i];
      check("run_busy", busy[i], 1);
      check("run_done", done[i], 0);
      check("run_sig",  sig[i],  exp);
      check("run_pass", pass[i], 0);
      if (k <= w)              r = (warm_fix >= 0) ? 6'(warm_fix) : 6'($urandom);
      else if (dir_q.size()>0) r = dir_q.pop_front();
      else                     r = 6'($urandom);
      resp[i] = r;
      if (k > w) exp = fold(exp, r);
      @(posedge ck);
    end
    @(negedge ck);
    start[i] = 1'b0;
    check("end_busy", busy[i], 0);
    check("end_done", done[i], 1);
    check("end_sig",  sig[i],  exp);
    check("end_pass", pass[i], want_pass(exp, golden[i]));
    fin = exp;
  endtask

  initial begin
    logic [15:0] fin;
    int          ri;
    int          rl;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b1; len[i] = 8'd5; resp[i] = 6'h3F; golden[i] = 16'h0000;
    end
    repeat (2) @(posedge ck);
    @(negedge ck);
    for (int i = 0; i < N; i++) begin
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_pass", pass[i], 0);
      check("rst_sig",  sig[i],  seed_of(i));
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) start[i] = 1'b0;

    // Zero-length request in IDLE is not a run.
    start[2] = 1'b1; len[2] = 8'd0;
    @(posedge ck);
    @(negedge ck);
    start[2] = 1'b0;
    check("len0_idle_busy", busy[2], 0);
    check("len0_idle_done", done[2], 0);
    check("len0_idle_sig",  sig[2],  16'hFFFF);

    dir_q = '{6'h00};
    run(0, 1, 1'b0, fin);
    check("vec_efdf", sig[0], 16'hEFDF);

    golden[1] = 16'h0041;
    dir_q = '{6'h2A, 6'h15};
    run(1, 2, 1'b0, fin);
    check("vec_0041", sig[1], 16'h0041);
`ifdef S298_MISR_COMPARE_EN
    check("pass_match", pass[1], 1);
`else
    check("pass_match", pass[1], 0);
`endif

    // Restart straight from DONE with a non-matching golden.
    golden[1] = 16'h0040;
    dir_q = '{6'h2A, 6'h15};
    run(1, 2, 1'b0, fin);
    check("pass_mismatch", pass[1], 0);

    // Warm-up samples must not reach the signature; START/LEN noise during the run ignored.
    warm_fix = 6'h3F;
    dir_q = '{6'h00, 6'h00, 6'h00};
    run(2, 3, 1'b1, fin);
    warm_fix = -1;
    repeat (3) begin
      @(negedge ck);
      check("hold_sig",  sig[2],  fin);
      check("hold_done", done[2], 1);
    end

    // START with LEN=0 in DONE returns to IDLE.
    start[2] = 1'b1; len[2] = 8'd0;
    @(posedge ck);
    @(negedge ck);
    start[2] = 1'b0;
    check("len0_done_done", done[2], 0);
    check("len0_done_busy", busy[2], 0);
    check("len0_done_pass", pass[2], 0);

    // Reset in the middle of CAPTURE aborts everything.
    start[2] = 1'b1; len[2] = 8'd10;
    @(posedge ck);
    @(negedge ck);
    start[2] = 1'b0;
    repeat (6) begin
      resp[2] = 6'($urandom);
      @(posedge ck);
      @(negedge ck);
    end
    check("pre_rst_busy", busy[2], 1);
    rst = 1'b1;
    @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("mid_rst_busy", busy[i], 0);
      check("mid_rst_done", done[i], 0);
      check("mid_rst_pass", pass[i], 0);
      check("mid_rst_sig",  sig[i],  seed_of(i));
    end
    run(2, 5, 1'b1, fin);

    // Random runs across all instances, with and without idle gaps.
    repeat (15) begin
      ri = $urandom_range(0, N - 1);
      rl = $urandom_range(1, 12);
      golden[ri] = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge ck);
      run(ri, rl, 1'($urandom_range(0, 1)), fin);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
